pipeline_exec: RTL and testbench

//  Execute stage fed by the decode/execute pipeline register; forwards operands, runs ALU

---
 rtl/pipeline_exec_if.sv | 51 +++++
 rtl/pipeline_exec.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_pipeline_exec.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/pipeline_exec_if.sv
// Execute-stage bus: decode/execute register inputs, writeback forwarding
// inputs, and the registered execute/memory outputs plus the upstream stall.
interface pipeline_exec_if #(
    parameter int DW = 32,
    parameter int RW = 4
) ();
    // decode/execute register
    logic          wmemi;
    logic          rmemi;
    logic          wregi;
    logic          wpci;
    logic          CondEni;
    logic          immFi;
    logic [1:0]    jmpi;
    logic [2:0]    ALUInsi;
    logic [DW-1:0] R2ri;
    logic [DW-1:0] R3ri;
    logic [RW-1:0] R2i;
    logic [RW-1:0] R3i;
    logic [RW-1:0] DestRi;
    // writeback stage
    logic          wb_wreg;
    logic [RW-1:0] wb_dest;
    logic [DW-1:0] wb_data;
    // execute/memory register and stall
    logic          stall_o;
    logic          wmemo;
    logic          rmemo;
    logic          wrego;
    logic          wpco;
    logic [1:0]    jmpo;
    logic [RW-1:0] DestRo;
    logic [DW-1:0] alu_res;
    logic [DW-1:0] st_data;
    logic          flag_z;
    logic          flag_n;

    modport slave (
        input  wmemi, rmemi, wregi, wpci, CondEni, immFi, jmpi, ALUInsi,
               R2ri, R3ri, R2i, R3i, DestRi, wb_wreg, wb_dest, wb_data,
        output stall_o, wmemo, rmemo, wrego, wpco, jmpo, DestRo, alu_res,
               st_data, flag_z, flag_n
    );

    modport master (
        output wmemi, rmemi, wregi, wpci, CondEni, immFi, jmpi, ALUInsi,
               R2ri, R3ri, R2i, R3i, DestRi, wb_wreg, wb_dest, wb_data,
        input  stall_o, wmemo, rmemo, wrego, wpco, jmpo, DestRo, alu_res,
               st_data, flag_z, flag_n
    );
endinterface

// File: rtl/pipeline_exec.sv
// Execute stage: operand forwarding, ALU with a lane-serial 4x8-bit alpha
// multiply (one lane per cycle, upstream stalled meanwhile), Z/N flags, and
// the registered execute/memory pipeline register.
// Only DW=32 with LANES=4 (8-bit lanes) is supported.
module pipeline_exec #(
    parameter int DW    = 32,
    parameter int RW    = 4,
    parameter int LANES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    pipeline_exec_if.slave  bus
);
    localparam int LW      = DW / LANES;
    localparam int LANE_IW = $clog2(LANES);
    localparam logic [LANE_IW-1:0] LAST_LANE = LANE_IW'(LANES - 1);

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_SHL   = 3'd4;
    localparam logic [2:0] OP_SHR   = 3'd5;
    localparam logic [2:0] OP_VMUL  = 3'd6;
    localparam logic [2:0] OP_VADDS = 3'd7;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    // control fields of an instruction held across a multiply
    typedef struct packed {
        logic          wmem;
        logic          rmem;
        logic          wreg;
        logic          wpc;
        logic          cen;
        logic [1:0]    jmp;
        logic [RW-1:0] dest;
    } ctrl_t;

    // execute/memory register contents (flags kept separately: flush keeps them)
    typedef struct packed {
        logic          wmem;
        logic          rmem;
        logic          wreg;
        logic          wpc;
        logic [1:0]    jmp;
        logic [RW-1:0] dest;
        logic [DW-1:0] res;
        logic [DW-1:0] st;
    } out_t;

    // unsigned 8x8 alpha multiply: upper byte of the 16-bit product
    function automatic logic [LW-1:0] vmul_lane(input logic [LW-1:0] a, input logic [LW-1:0] b);
        logic [2*LW-1:0] p;
        p = {{LW{1'b0}}, a} * {{LW{1'b0}}, b};
        return p[2*LW-1:LW];
    endfunction

    // unsigned saturating 8-bit add
    function automatic logic [LW-1:0] vadds_lane(input logic [LW-1:0] a, input logic [LW-1:0] b);
        logic [LW:0]   s;
        logic [LW-1:0] r;
        s = {1'b0, a} + {1'b0, b};
        if (s[LW]) begin
            r = {LW{1'b1}};
        end else begin
            r = s[LW-1:0];
        end
        return r;
    endfunction

    // single-cycle ALU; VMUL is produced by the lane-serial path instead
    function automatic logic [DW-1:0] alu_calc(input logic [2:0] op, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        logic [DW-1:0] r;
        r = '0;
        case (op)
            OP_ADD:   r = a + b;
            OP_SUB:   r = a - b;
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_SHL:   r = a << b[4:0];
            OP_SHR:   r = a >> b[4:0];
            OP_VADDS: begin
                for (int i = 0; i < LANES; i++) begin
                    r[i*LW +: LW] = vadds_lane(a[i*LW +: LW], b[i*LW +: LW]);
                end
            end
            OP_VMUL:  r = '0;
            default:  r = '0;
        endcase
        return r;
    endfunction

    // EX/MEM result beats writeback; a load in EX/MEM has no value yet
    function automatic logic [DW-1:0] fwd(input logic [RW-1:0] idx, input logic [DW-1:0] regv,
                                          input logic ex_wreg, input logic ex_rmem,
                                          input logic [RW-1:0] ex_dest, input logic [DW-1:0] ex_res,
                                          input logic wbw, input logic [RW-1:0] wbd,
                                          input logic [DW-1:0] wbv);
        logic [DW-1:0] v;
        if (ex_wreg && !ex_rmem && (ex_dest == idx)) begin
            v = ex_res;
        end else if (wbw && (wbd == idx)) begin
            v = wbv;
        end else begin
            v = regv;
        end
        return v;
    endfunction

    function automatic out_t make_out(input ctrl_t c, input logic [DW-1:0] res, input logic [DW-1:0] st);
        out_t o;
        o.wmem = c.wmem;
        o.rmem = c.rmem;
        o.wreg = c.wreg;
        o.wpc  = c.wpc;
        o.jmp  = c.jmp;
        o.dest = c.dest;
        o.res  = res;
        o.st   = st;
        return o;
    endfunction

    state_t               state_q, state_d;
    logic [LANE_IW-1:0]   lane_q, lane_d;
    logic [DW-1:0]        a_q, a_d;
    logic [DW-1:0]        b_q, b_d;
    logic [DW-1:0]        acc_q, acc_d;
    logic [DW-1:0]        st_hold_q, st_hold_d;
    ctrl_t                ctrl_q, ctrl_d;
    out_t                 out_q, out_d;
    logic                 flag_z_q, flag_z_d;
    logic                 flag_n_q, flag_n_d;

    ctrl_t                ctrl_in_s;
    logic [DW-1:0]        fwd_a_s;
    logic [DW-1:0]        fwd_b_s;
    logic [DW-1:0]        op_b_s;
    logic [DW-1:0]        alu_s;
    logic [DW-1:0]        mul_a_s;
    logic [DW-1:0]        mul_b_s;
    logic [LANE_IW-1:0]   lane_idx_s;
    logic [LW-1:0]        lane_res_s;
    logic [DW-1:0]        mul_word_s;
    logic                 stall_s;

    // operand forwarding, single-cycle ALU and the current multiply lane
    always_comb begin
        ctrl_in_s.wmem = bus.wmemi;
        ctrl_in_s.rmem = bus.rmemi;
        ctrl_in_s.wreg = bus.wregi;
        ctrl_in_s.wpc  = bus.wpci;
        ctrl_in_s.cen  = bus.CondEni;
        ctrl_in_s.jmp  = bus.jmpi;
        ctrl_in_s.dest = bus.DestRi;

        fwd_a_s = fwd(bus.R2i, bus.R2ri, out_q.wreg, out_q.rmem, out_q.dest, out_q.res,
                      bus.wb_wreg, bus.wb_dest, bus.wb_data);
        fwd_b_s = fwd(bus.R3i, bus.R3ri, out_q.wreg, out_q.rmem, out_q.dest, out_q.res,
                      bus.wb_wreg, bus.wb_dest, bus.wb_data);
        op_b_s  = bus.immFi ? bus.R3ri : fwd_b_s;
        alu_s   = alu_calc(bus.ALUInsi, fwd_a_s, op_b_s);

        // lane 0 uses the live operands; later lanes use the latched copy
        if (state_q == ST_MUL) begin
            mul_a_s    = a_q;
            mul_b_s    = b_q;
            lane_idx_s = lane_q;
            mul_word_s = acc_q;
        end else begin
            mul_a_s    = fwd_a_s;
            mul_b_s    = op_b_s;
            lane_idx_s = '0;
            mul_word_s = '0;
        end
        lane_res_s = vmul_lane(mul_a_s[lane_idx_s*LW +: LW], mul_b_s[lane_idx_s*LW +: LW]);
        mul_word_s[lane_idx_s*LW +: LW] = lane_res_s;
    end

    // FSM next state, output register load (result or bubble), flags, stall
    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        st_hold_d = st_hold_q;
        ctrl_d    = ctrl_q;
        out_d     = '0;
        flag_z_d  = flag_z_q;
        flag_n_d  = flag_n_q;
        stall_s   = 1'b0;
        if (rst || flush) begin
            state_d = ST_IDLE;
            lane_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.ALUInsi == OP_VMUL) begin
                        stall_s   = 1'b1;
                        a_d       = fwd_a_s;
                        b_d       = op_b_s;
                        acc_d     = mul_word_s;
                        st_hold_d = fwd_b_s;
                        ctrl_d    = ctrl_in_s;
                        state_d   = ST_MUL;
                        lane_d    = LANE_IW'(1);
                    end else begin
                        out_d = make_out(ctrl_in_s, alu_s, fwd_b_s);
                        if (bus.CondEni) begin
                            flag_z_d = (alu_s == '0);
                            flag_n_d = alu_s[DW-1];
                        end else begin
                            flag_z_d = flag_z_q;
                            flag_n_d = flag_n_q;
                        end
                    end
                end
                ST_MUL: begin
                    if (lane_q == LAST_LANE) begin
                        out_d   = make_out(ctrl_q, mul_word_s, st_hold_q);
                        state_d = ST_IDLE;
                        lane_d  = '0;
                        if (ctrl_q.cen) begin
                            flag_z_d = (mul_word_s == '0);
                            flag_n_d = mul_word_s[DW-1];
                        end else begin
                            flag_z_d = flag_z_q;
                            flag_n_d = flag_n_q;
                        end
                    end else begin
                        stall_s = 1'b1;
                        acc_d   = mul_word_s;
                        lane_d  = lane_q + LANE_IW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    lane_d  = '0;
                end
            endcase
        end
    end

    // state, multiply holding registers, execute/memory register and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lane_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            st_hold_q <= '0;
            ctrl_q    <= '0;
            out_q     <= '0;
            flag_z_q  <= 1'b0;
            flag_n_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            st_hold_q <= st_hold_d;
            ctrl_q    <= ctrl_d;
            out_q     <= out_d;
            flag_z_q  <= flag_z_d;
            flag_n_q  <= flag_n_d;
        end
    end

    assign bus.stall_o = stall_s;
    assign bus.wmemo   = out_q.wmem;
    assign bus.rmemo   = out_q.rmem;
    assign bus.wrego   = out_q.wreg;
    assign bus.wpco    = out_q.wpc;
    assign bus.jmpo    = out_q.jmp;
    assign bus.DestRo  = out_q.dest;
    assign bus.alu_res = out_q.res;
    assign bus.st_data = out_q.st;
    assign bus.flag_z  = flag_z_q;
    assign bus.flag_n  = flag_n_q;
endmodule

// File: tb/tb_pipeline_exec.sv
// Directed bench for pipeline_exec: a table of single-cycle instructions with
// hand-computed results, then hand-written VMUL, flush and reset sequences.
module tb_pipeline_exec;
    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    pipeline_exec_if #(.DW(32), .RW(4)) bus ();

    pipeline_exec #(.DW(32), .RW(4), .LANES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  r2i;
        logic [31:0] r2r;
        logic [3:0]  r3i;
        logic [31:0] r3r;
        logic        immf;
        logic        cen;
        logic        wreg;
        logic        rmem;
        logic [3:0]  dest;
        logic        wbw;
        logic [3:0]  wbd;
        logic [31:0] wbdata;
        logic [31:0] eres;
        logic [31:0] est;
        logic        ez;
        logic        en;
    } vec_t;

    vec_t vecs [12];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [3:0] r2i, input logic [31:0] r2r,
                         input logic [3:0] r3i, input logic [31:0] r3r, input logic immf,
                         input logic cen, input logic wreg, input logic rmem, input logic [3:0] dest);
        bus.ALUInsi = op;
        bus.R2i     = r2i;
        bus.R2ri    = r2r;
        bus.R3i     = r3i;
        bus.R3ri    = r3r;
        bus.immFi   = immf;
        bus.CondEni = cen;
        bus.wregi   = wreg;
        bus.rmemi   = rmem;
        bus.DestRi  = dest;
        bus.wmemi   = 1'b0;
        bus.wpci    = 1'b0;
        bus.jmpi    = 2'd0;
    endtask

    task automatic set_wb(input logic w, input logic [3:0] d, input logic [31:0] v);
        bus.wb_wreg = w;
        bus.wb_dest = d;
        bus.wb_data = v;
    endtask

    initial begin
        //              op    r2i   r2r            r3i   r3r            imm   cen   wreg  rmem  dest   wbw   wbd   wbdata         eres           est            z     n
        vecs[0]  = '{3'd0, 4'd1, 32'd5,         4'd2, 32'd7,         1'b0, 1'b0, 1'b1, 1'b0, 4'd3,  1'b0, 4'd0, 32'd0,         32'd12,        32'd7,         1'b0, 1'b0};
        vecs[1]  = '{3'd0, 4'd3, 32'd0,         4'd2, 32'd1,         1'b0, 1'b0, 1'b1, 1'b0, 4'd4,  1'b1, 4'd3, 32'd100,       32'd13,        32'd1,         1'b0, 1'b0};
        vecs[2]  = '{3'd1, 4'd1, 32'd4,         4'd2, 32'd4,         1'b0, 1'b1, 1'b0, 1'b0, 4'd5,  1'b0, 4'd0, 32'd0,         32'd0,         32'd4,         1'b1, 1'b0};
        vecs[3]  = '{3'd1, 4'd1, 32'd3,         4'd2, 32'd4,         1'b0, 1'b1, 1'b0, 1'b0, 4'd5,  1'b0, 4'd0, 32'd0,         32'hFFFF_FFFF, 32'd4,         1'b0, 1'b1};
        vecs[4]  = '{3'd2, 4'd6, 32'hF0F0_FFFF, 4'd7, 32'h0FF0_00FF, 1'b0, 1'b0, 1'b1, 1'b0, 4'd8,  1'b1, 4'd7, 32'h0000_FF00, 32'h0000_FF00, 32'h0000_FF00, 1'b0, 1'b1};
        vecs[5]  = '{3'd3, 4'd8, 32'd0,         4'd9, 32'h1234_0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'd9,  1'b0, 4'd0, 32'd0,         32'h1234_FF00, 32'h1234_0000, 1'b0, 1'b0};
        vecs[6]  = '{3'd4, 4'd1, 32'd3,         4'd9, 32'd4,         1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0, 32'd0,         32'h0000_0030, 32'h1234_FF00, 1'b0, 1'b0};
        vecs[7]  = '{3'd5, 4'd1, 32'h8000_0000, 4'd2, 32'd31,        1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0, 32'd0,         32'd1,         32'd31,        1'b0, 1'b0};
        vecs[8]  = '{3'd7, 4'd1, 32'hF0F0_0101, 4'd2, 32'h2010_0102, 1'b0, 1'b1, 1'b1, 1'b0, 4'd15, 1'b0, 4'd0, 32'd0,         32'hFFFF_0203, 32'h2010_0102, 1'b0, 1'b1};
        vecs[9]  = '{3'd0, 4'd15, 32'd0,        4'd0, 32'h0000_FDFD, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd0, 32'd0,         32'd0,         32'h0000_FDFD, 1'b1, 1'b0};
        vecs[10] = '{3'd0, 4'd1, 32'h100,       4'd2, 32'h20,        1'b0, 1'b0, 1'b1, 1'b1, 4'd10, 1'b0, 4'd0, 32'd0,         32'h120,       32'h20,        1'b1, 1'b0};
        vecs[11] = '{3'd0, 4'd10, 32'd7,        4'd11, 32'd1,        1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 4'd10, 32'h50,       32'h51,        32'd1,         1'b1, 1'b0};

        // reset: two cycles with quiet inputs
        rst   = 1'b1;
        flush = 1'b0;
        drive(3'd0, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        set_wb(1'b0, 4'd0, 32'd0);
        tick();
        tick();
        check("rst alu_res", bus.alu_res, 32'd0);
        check("rst st_data", bus.st_data, 32'd0);
        check("rst ctrl", {28'd0, bus.wmemo, bus.rmemo, bus.wrego, bus.wpco}, 32'd0);
        check("rst jmp/dest", {26'd0, bus.jmpo, bus.DestRo}, 32'd0);
        check("rst flags", {30'd0, bus.flag_z, bus.flag_n}, 32'd0);
        check("rst stall", {31'd0, bus.stall_o}, 32'd0);
        rst = 1'b0;

        // single-cycle instruction table
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].op, vecs[i].r2i, vecs[i].r2r, vecs[i].r3i, vecs[i].r3r, vecs[i].immf,
                  vecs[i].cen, vecs[i].wreg, vecs[i].rmem, vecs[i].dest);
            set_wb(vecs[i].wbw, vecs[i].wbd, vecs[i].wbdata);
            #1;
            check($sformatf("v%0d stall", i), {31'd0, bus.stall_o}, 32'd0);
            tick();
            check($sformatf("v%0d alu_res", i), bus.alu_res, vecs[i].eres);
            check($sformatf("v%0d st_data", i), bus.st_data, vecs[i].est);
            check($sformatf("v%0d flag_z", i), {31'd0, bus.flag_z}, {31'd0, vecs[i].ez});
            check($sformatf("v%0d flag_n", i), {31'd0, bus.flag_n}, {31'd0, vecs[i].en});
            check($sformatf("v%0d wrego/rmemo", i), {30'd0, bus.wrego, bus.rmemo},
                  {30'd0, vecs[i].wreg, vecs[i].rmem});
            check($sformatf("v%0d DestRo", i), {28'd0, bus.DestRo}, {28'd0, vecs[i].dest});
        end

        // VMUL: four cycles, stall 1,1,1,0, held control emerges with the result
        drive(3'd6, 4'd1, 32'hFF80_40FF, 4'd2, 32'hFF80_8001, 1'b0, 1'b1, 1'b1, 1'b0, 4'd5);
        bus.wmemi = 1'b1;
        bus.wpci  = 1'b1;
        bus.jmpi  = 2'd2;
        set_wb(1'b0, 4'd0, 32'd0);
        #1;
        check("vmul c0 stall", {31'd0, bus.stall_o}, 32'd1);
        tick();
        check("vmul c1 stall", {31'd0, bus.stall_o}, 32'd1);
        check("vmul c1 bubble wrego", {31'd0, bus.wrego}, 32'd0);
        check("vmul c1 bubble res", bus.alu_res, 32'd0);
        set_wb(1'b1, 4'd1, 32'd0);
        tick();
        check("vmul c2 stall", {31'd0, bus.stall_o}, 32'd1);
        tick();
        check("vmul c3 stall", {31'd0, bus.stall_o}, 32'd0);
        tick();
        check("vmul alu_res", bus.alu_res, 32'hFE40_2000);
        check("vmul st_data", bus.st_data, 32'hFF80_8001);
        check("vmul ctrl", {28'd0, bus.wmemo, bus.rmemo, bus.wrego, bus.wpco}, 32'b1011);
        check("vmul jmp/dest", {26'd0, bus.jmpo, bus.DestRo}, {26'd0, 2'd2, 4'd5});
        check("vmul flags", {30'd0, bus.flag_z, bus.flag_n}, 32'b01);

        // VMUL aborted by flush in its second cycle; flags survive
        drive(3'd6, 4'd1, 32'h0101_0101, 4'd2, 32'h0202_0202, 1'b0, 1'b1, 1'b1, 1'b0, 4'd6);
        set_wb(1'b0, 4'd0, 32'd0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(3'd0, 4'd1, 32'd2, 4'd2, 32'd3, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7);
        #1;
        check("flush stall", {31'd0, bus.stall_o}, 32'd0);
        check("flush wrego", {31'd0, bus.wrego}, 32'd0);
        check("flush alu_res", bus.alu_res, 32'd0);
        check("flush flags kept", {30'd0, bus.flag_z, bus.flag_n}, 32'b01);
        tick();
        check("post-flush add", bus.alu_res, 32'd5);
        check("post-flush wrego/dest", {27'd0, bus.wrego, bus.DestRo}, {27'd0, 1'b1, 4'd7});

        // reset mid-VMUL clears everything including flags
        drive(3'd6, 4'd1, 32'hFFFF_FFFF, 4'd2, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 4'd9);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(3'd0, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        #1;
        check("rst-mid stall", {31'd0, bus.stall_o}, 32'd0);
        check("rst-mid wrego", {31'd0, bus.wrego}, 32'd0);
        check("rst-mid alu_res", bus.alu_res, 32'd0);
        check("rst-mid flags", {30'd0, bus.flag_z, bus.flag_n}, 32'd0);
        tick();
        check("rst-mid idle stall", {31'd0, bus.stall_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
